// File: rtl/mmio_timer_pkg.sv
// Register map, CTRL/STATUS bit positions and address-window helper for mmio_timer.
// Latency: n/a (definitions only); backpressure: n/a.
package mmio_timer_pkg;

  // Word indices (byte offset >> 2) within the 32-byte window.
  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_LOAD     = 3'd1;
  localparam logic [2:0] OFS_COUNT    = 3'd2;
  localparam logic [2:0] OFS_STATUS   = 3'd3;
  localparam logic [2:0] OFS_PRESCALE = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Core data-memory bus as seen by a memory-mapped responder.
// Latency: loads combinational, stores take effect at the clock edge; backpressure: none.
interface mmio_timer_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;
  logic        irq;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData, Sel, irq);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, Sel, irq);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Divides clk by (div+1) while enabled; tick is combinational from the held count.
// Latency: tick in the cycle pscnt == div; backpressure: none.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] div,
  output logic        tick
);
  logic [31:0] pscnt_q, pscnt_d;

  assign tick = en && (pscnt_q == div);

  always_comb begin
    pscnt_d = pscnt_q + 32'd1;
    if (!en || clr || tick) pscnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) pscnt_q <= '0;
    else       pscnt_q <= pscnt_d;
  end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and level irq.
// Latency: loads zero-cycle, stores visible next cycle; backpressure: none (always ready).
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  mmio_timer_if.slave bus
);
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] prescale_q, prescale_d;
  logic        exp_q, exp_d;
  logic        sel, wr, tick, clr_ps, expire;
  logic [2:0]  ofs;
  logic [31:0] rdata;
  logic        unused_adr;

  assign sel        = in_window(bus.DataAdr, BASE);
  assign ofs        = bus.DataAdr[4:2];
  assign wr         = bus.MemWrite && sel;
  assign clr_ps     = wr && (ofs == OFS_CTRL);
  assign expire     = tick && (count_q == 32'd0);
  assign unused_adr = ^bus.DataAdr[1:0];

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (clr_ps),
    .div   (prescale_q),
    .tick  (tick)
  );

  // Tick effects first, core writes override them, expiry set wins over clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    exp_d      = exp_q;
    if (tick) begin
      if (count_q != 32'd0)   count_d = count_q - 32'd1;
      else if (ctrl_q[CTRL_AR]) count_d = load_q;
      else                    ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr) begin
      case (ofs)
        OFS_CTRL:     ctrl_d     = bus.WriteData[2:0];
        OFS_LOAD:     load_d     = bus.WriteData;
        OFS_COUNT:    count_d    = bus.WriteData;
        OFS_STATUS:   if (bus.WriteData[STATUS_EXP]) exp_d = 1'b0;
        OFS_PRESCALE: prescale_d = bus.WriteData;
        default:      ;
      endcase
    end
    if (expire) exp_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (ofs)
        OFS_CTRL:     rdata = {29'd0, ctrl_q};
        OFS_LOAD:     rdata = load_q;
        OFS_COUNT:    rdata = count_q;
        OFS_STATUS:   rdata = {31'd0, exp_q};
        OFS_PRESCALE: rdata = prescale_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Sel      = sel;
  assign bus.irq      = exp_q & ctrl_q[CTRL_IE];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      exp_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      exp_q      <= exp_d;
    end
  end
endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: register-array model checked every cycle plus directed literal reads.
// Inputs driven in the low clock phase; outputs sampled 2 time units after the rising edge.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  mmio_timer_if bus ();

  mmio_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: registers as a word array indexed by byte offset / 4, plus a free prescale counter.
  logic [31:0] m_reg [8];
  logic [31:0] m_ps;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt [8];
    logic        we, tk;
    int          w;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
      m_ps = 32'd0;
      return;
    end
    nxt = m_reg;
    w  = int'(bus.DataAdr[4:2]);
    we = bus.MemWrite && (bus.DataAdr[31:5] == BASE[31:5]);
    tk = m_reg[0][0] && (m_ps == m_reg[4]);
    if (tk) begin
      if (m_reg[2] > 0) nxt[2] = m_reg[2] - 1;
      else if (m_reg[0][1]) nxt[2] = m_reg[1];
      else nxt[0] = m_reg[0] & 32'd6;
    end
    if (we) begin
      if (w == 0) nxt[0] = bus.WriteData & 32'd7;
      else if (w == 3) begin
        if (bus.WriteData[0]) nxt[3] = 32'd0;
      end else if (w < 5) nxt[w] = bus.WriteData;
    end
    if (tk && m_reg[2] == 0) nxt[3] = 32'd1;
    if (!m_reg[0][0] || tk || (we && w == 0)) m_ps = 32'd0;
    else m_ps = m_ps + 1;
    m_reg = nxt;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
    m_ps = 32'd0;
  end

  always @(posedge clk) model_step();

  function automatic logic [31:0] exp_rd(input logic [31:0] adr);
    if (adr[31:5] != BASE[31:5]) return 32'd0;
    if (adr[4:2] > 3'd4) return 32'd0;
    return m_reg[adr[4:2]];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cyc_sel", {31'd0, bus.Sel}, {31'd0, bus.DataAdr[31:5] == BASE[31:5]});
      chk("cyc_rdata", bus.ReadData, exp_rd(bus.DataAdr));
      chk("cyc_irq", {31'd0, bus.irq}, {31'd0, m_reg[3][0] & m_reg[0][2]});
    end
  end

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = BASE + 32'(ofs);
    bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] ofs, input logic [31:0] exp, input string nm);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = BASE + 32'(ofs);
    #1;
    chk(nm, bus.ReadData, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = BASE;
    bus.WriteData = 32'd0;
    step(3);
    reset = 1'b0;

    // Reset state and decode
    for (int i = 0; i < 8; i++) begin
      rd(8'(i * 4), 32'd0, "reset_rd");
      chk("reset_sel", {31'd0, bus.Sel}, 32'd1);
    end
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    bus.DataAdr = BASE + 32'h20;
    #1;
    chk("out_sel", {31'd0, bus.Sel}, 32'd0);
    chk("out_rdata", bus.ReadData, 32'd0);
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h14, 32'd0, "hole_wr");
    rd(8'h18, 32'd0, "hole_18");

    // One-shot
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd3);
    wr(8'h10, 32'd0);
    wr(8'h00, 32'd5);
    rd(8'h08, 32'd3, "os_cnt3");
    step(1); rd(8'h08, 32'd2, "os_cnt2");
    step(1); rd(8'h08, 32'd1, "os_cnt1");
    step(1); rd(8'h08, 32'd0, "os_cnt0");
    rd(8'h0C, 32'd0, "os_exp_early");
    chk("os_irq_early", {31'd0, bus.irq}, 32'd0);
    step(1); rd(8'h0C, 32'd1, "os_exp");
    chk("os_irq", {31'd0, bus.irq}, 32'd1);
    rd(8'h00, 32'd4, "os_en_clr");
    step(3); rd(8'h08, 32'd0, "os_cnt_hold");
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'd0);
    rd(8'h0C, 32'd0, "os_cleanup");

    // Auto-reload with prescale
    wr(8'h04, 32'd2);
    wr(8'h08, 32'd2);
    wr(8'h10, 32'd1);
    wr(8'h00, 32'd3);
    step(5);
    rd(8'h0C, 32'd0, "ar_exp_c5");
    rd(8'h08, 32'd0, "ar_cnt_c5");
    step(1);
    rd(8'h0C, 32'd1, "ar_exp_c6");
    rd(8'h08, 32'd2, "ar_reload");
    wr(8'h0C, 32'd1);
    rd(8'h0C, 32'd0, "ar_w1c");
    step(4);
    rd(8'h0C, 32'd0, "ar_exp_c11");
    step(1);
    rd(8'h0C, 32'd1, "ar_exp_c12");
    chk("ar_irq", {31'd0, bus.irq}, 32'd0);
    wr(8'h0C, 32'd1);
    rd(8'h0C, 32'd0, "ar_w1c2");

    // Clear collides with expiry at cycle 18
    step(4);
    wr(8'h0C, 32'd1);
    rd(8'h0C, 32'd1, "clr_collide");

    // COUNT write collides with a tick at cycle 20
    step(1);
    wr(8'h08, 32'h100);
    rd(8'h08, 32'h100, "cnt_collide");

    // Reset mid-run
    wr(8'h00, 32'd7);
    wr(8'h08, 32'd5);
    rd(8'h08, 32'd5, "pre_rst_cnt");
    chk("pre_rst_irq", {31'd0, bus.irq}, 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) rd(8'(i * 4), 32'd0, "rst_rd");
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    rd(8'h08, 32'd0, "rst_cnt");
    step(10);
    rd(8'h08, 32'd0, "rst_cnt_hold");
    rd(8'h00, 32'd0, "rst_ctrl_hold");

    step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped countdown timer that answers the core's data-memory bus (MemWrite / DataAdr / WriteData / ReadData) as a responder, in parallel with dmem. The core issues loads and stores. The timer decodes its own address window, updates its registers on stores, and returns register contents on loads. It raises a level interrupt on expiry. The top level muxes ReadData between dmem and the timer using `Sel`.

## Interface
- BASE, 32'h0000_1000, window base address; the window is 32 bytes, and BASE[4:0] must be 0.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  32  byte address from the core.
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from DataAdr and current register state.
- Sel  out  1  combinational; asserted when DataAdr[31:5] == BASE[31:5].
- irq  out  1  level interrupt, equal to STATUS.EXP & CTRL.IE.

## Operation
- Registers are selected by word offset DataAdr[4:2]. DataAdr[1:0] are ignored, and only full-word access is supported.
  - 0x00 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE. Bits [31:3] read as 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: 32-bit current count. A store writes it directly.
  - 0x0C STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x10 PRESCALE: 32-bit divider.
  - 0x14–0x1C: reads return 0; writes are ignored.
- A register write happens at the rising edge when MemWrite && Sel.
- ReadData is 0 when Sel is low.
- Prescaler:
  - Internal counter pscnt.
  - When EN=1: if pscnt == PRESCALE, assert tick and set pscnt←0; otherwise pscnt←pscnt+1.
  - When EN=0: pscnt←0 and no tick.
  - Any write to CTRL sets pscnt←0.
- Behaviour on tick:
  - If COUNT != 0: COUNT←COUNT−1.
  - If COUNT == 0: EXP←1. Then, if AR=1, COUNT←LOAD; if AR=0, EN←0.
- Expiry period with AR=1 is (LOAD+1)·(PRESCALE+1) cycles.
- Simultaneous events:
  - A core write to COUNT takes priority over the tick's decrement or reload.
  - A core write to CTRL takes priority over the EN auto-clear.
  - Setting EXP takes priority over a same-cycle write-1-to-clear, so EXP stays 1.
  - Writing PRESCALE does not reset pscnt. If pscnt > PRESCALE after the write, pscnt keeps counting up and wraps through 2^32 before the next tick. Software writes CTRL afterward to restart the prescaler.
- COUNT decrements only when nonzero, so it never wraps.

## Timing
- All registers, pscnt and EXP reset to 0. irq resets to 0.
- Sel and ReadData are purely combinational. Loads have zero latency, matching single-cycle dmem behaviour.
- A store is visible on ReadData in the cycle after the write edge.
- irq follows EXP/IE with no extra delay: it is high in the cycle after the edge that sets EXP while IE=1.
- Reset asserted mid-count takes priority over everything. All state is 0 at the next edge, and the timer stays stopped until software re-enables it.
- The tick is internal. COUNT changes at the same edge where pscnt == PRESCALE is sampled.

## Structure
- Package `mmio_timer_pkg`:
  - Offset constants: OFS_CTRL, OFS_LOAD, OFS_COUNT, OFS_STATUS, OFS_PRESCALE.
  - CTRL bit indices: CTRL_EN, CTRL_AR, CTRL_IE.
  - STATUS_EXP index.
- One sub-module, `timer_prescaler`. Inputs: clk, reset, en, clr, div[31:0]. Output: tick. It holds pscnt.
- The register file, decode and countdown live in `mmio_timer`.

## Test plan
- **Reset and decode.** After reset, read each offset at BASE → 0 and Sel=1. Read BASE+0x20 → Sel=0 and ReadData=0. Read BASE+0x18 → 0.
- **One-shot.** Write LOAD=3, COUNT=3, PRESCALE=0, then CTRL=EN|IE.
  - COUNT decrements each cycle: 2, 1, 0.
  - EXP=1 and irq=1 exactly 4 cycles after the CTRL write edge.
  - CTRL.EN reads 0 afterward, and COUNT holds 0.
- **Auto-reload with prescale.** Write LOAD=2, COUNT=2, PRESCALE=1, then CTRL=EN|AR.
  - EXP rises at cycle 6.
  - COUNT reloads to 2 and expires again 6 cycles later.
  - Write STATUS=1 between expiries → EXP=0. irq stays 0 throughout because IE=0.
- **Clear collision.** Arrange a write of STATUS=1 on the same edge as an expiry → EXP reads 1 afterward.
- **COUNT write collision.** With a tick due, write COUNT=0x100 on that edge → COUNT reads 0x100, not the decremented value.
- **Reset mid-run.** Assert reset for one cycle while COUNT=5 and EN=1 → all registers read 0, irq=0, and COUNT stays 0 for 10 cycles.
